// File: rtl/arrhythmia_infer_ctrl_if.sv
// ---------------------------------------------------------------------------
// arrhythmia_infer_ctrl_if
// Sample-in / result-out handshake bundle for arrhythmia_infer_ctrl.
//   in_valid  : producer has a sample on in_x
//   in_ready  : controller will accept the sample on the next rising edge
//   in_x      : 10-element sample, BITSIZE bits per element
//   out_valid : result FIFO head is valid
//   out_ready : consumer takes the head on the next rising edge
//   out_y     : 2-element result at the FIFO head
//   out_class : 1 when element 1 of out_y is greater than element 0
// Modports: slave = the controller, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface arrhythmia_infer_ctrl_if #(
  parameter int BITSIZE = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BITSIZE*10-1:0] in_x;
  logic                  out_valid;
  logic                  out_ready;
  logic [BITSIZE*2-1:0]  out_y;
  logic                  out_class;

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_y, out_class
  );

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_y, out_class
  );
endinterface

// File: rtl/arrhythmia_infer_ctrl.sv
// ---------------------------------------------------------------------------
// arrhythmia_infer_ctrl
// Flow-control wrapper around the fixed-latency arrhythmia inference
// datapath. Samples are issued to the datapath on dp_x; a token shift
// register marks which cycles carry a live sample, and dp_y is captured into
// a first-word-fall-through result FIFO when the token reaches the end.
// A credit counter (free FIFO slots minus samples in flight) gates in_ready,
// so every issued sample is guaranteed a FIFO slot under back-pressure.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   bus        : sample/result handshake (slave modport)
//   flush      : synchronous abort of in-flight and buffered results
//   dp_x       : registered datapath input (holds between accepts)
//   dp_y       : datapath output, valid LATENCY edges after dp_x update
//   busy       : any token in flight or FIFO non-empty
//   perf_*_cnt : saturating accept/pop/stall counters, present only when
//                ARR_PERF_CNT_EN is defined
//
// Optional feature macro: ARR_PERF_CNT_EN
// ---------------------------------------------------------------------------
module arrhythmia_infer_ctrl #(
  parameter int BITSIZE    = 16,
  parameter int LATENCY    = 24,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  arrhythmia_infer_ctrl_if.slave bus,
  input  logic                   flush,
  output logic [BITSIZE*10-1:0]  dp_x,
  input  logic [BITSIZE*2-1:0]   dp_y,
  output logic                   busy
`ifdef ARR_PERF_CNT_EN
  ,
  output logic [31:0]            perf_in_cnt,
  output logic [31:0]            perf_out_cnt,
  output logic [31:0]            perf_stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

  logic [LATENCY-1:0]    tok_q, tok_d;
  logic [BITSIZE*10-1:0] dp_x_q, dp_x_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic [BITSIZE*2-1:0]  mem [FIFO_DEPTH];

  logic                  in_ready;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [BITSIZE*2-1:0]  head;

  // Sign-magnitude a > b; a zero magnitude counts as non-negative so that
  // +0 and -0 compare equal.
  function automatic logic sm_gt(input logic [BITSIZE-1:0] a,
                                 input logic [BITSIZE-1:0] b);
    logic [BITSIZE-2:0] ma;
    logic [BITSIZE-2:0] mb;
    logic               na;
    logic               nb;
    logic               r;
    ma = a[BITSIZE-2:0];
    mb = b[BITSIZE-2:0];
    na = a[BITSIZE-1] && (ma != '0);
    nb = b[BITSIZE-1] && (mb != '0);
    if (na != nb) r = nb;
    else if (na)  r = (ma < mb);
    else          r = (ma > mb);
    return r;
  endfunction

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // reset is folded in so in_ready is low while reset is held, even
    // though the credit register already sits at its full value.
    in_ready = reset && (credit_q != '0) && !flush;
    accept   = bus.in_valid && in_ready;
    pop      = !fifo_empty && bus.out_ready && !flush;
    push     = tok_q[LATENCY-1] && !flush;

    tok_d  = flush ? '0 : {tok_q[LATENCY-2:0], accept};
    dp_x_d = accept ? bus.in_x : dp_x_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    credit_d = credit_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      credit_d = CREDIT_MAX;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      // Credit covers both FIFO occupancy and samples still in the pipe,
      // so it moves on accept/pop only, never on capture.
      if (accept && !pop)      credit_d = credit_q - CW'(1);
      else if (pop && !accept) credit_d = credit_q + CW'(1);
    end

    head = mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tok_q    <= '0;
      dp_x_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      credit_q <= CREDIT_MAX;
    end else begin
      tok_q    <= tok_d;
      dp_x_q   <= dp_x_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      credit_q <= credit_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= dp_y;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_y     = fifo_empty ? '0 : head;
  assign bus.out_class = !fifo_empty &&
                         sm_gt(head[2*BITSIZE-1:BITSIZE], head[BITSIZE-1:0]);
  assign dp_x          = dp_x_q;
  assign busy          = (|tok_q) || !fifo_empty;

  // Credit accounting makes a capture into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
                                  !(push && fifo_full));

`ifdef ARR_PERF_CNT_EN
  logic [31:0] perf_in_q, perf_in_d;
  logic [31:0] perf_out_q, perf_out_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall;

  always_comb begin
    stall        = !fifo_empty && !bus.out_ready;
    perf_in_d    = perf_in_q;
    perf_out_d   = perf_out_q;
    perf_stall_d = perf_stall_q;
    if (accept && (perf_in_q != '1))     perf_in_d    = perf_in_q + 32'd1;
    if (pop && (perf_out_q != '1))       perf_out_d   = perf_out_q + 32'd1;
    if (stall && (perf_stall_q != '1))   perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_in_q    <= '0;
      perf_out_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_in_q    <= perf_in_d;
      perf_out_q   <= perf_out_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_in_cnt    = perf_in_q;
  assign perf_out_cnt   = perf_out_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_arrhythmia_infer_ctrl.sv
module tb_arrhythmia_infer_ctrl;
  localparam int BITSIZE = 16;
  localparam int LATENCY = 24;
  localparam int DEPTH   = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic [159:0] dp_x;
  logic [31:0]  dp_y;
  logic         busy;
`ifdef ARR_PERF_CNT_EN
  logic [31:0]  perf_in_cnt, perf_out_cnt, perf_stall_cnt;
`endif

  arrhythmia_infer_ctrl_if #(.BITSIZE(BITSIZE)) bus ();

  arrhythmia_infer_ctrl #(.BITSIZE(BITSIZE), .LATENCY(LATENCY), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus), .flush(flush),
    .dp_x(dp_x), .dp_y(dp_y), .busy(busy)
`ifdef ARR_PERF_CNT_EN
    , .perf_in_cnt(perf_in_cnt), .perf_out_cnt(perf_out_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Stub datapath: dp_y at capture edge E0+LATENCY carries dp_x[31:0] issued at E0.
  logic [31:0] pipe [LATENCY-1];
  always @(posedge clk) begin
    pipe[0] <= dp_x[31:0];
    for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign dp_y = pipe[LATENCY-2];

  // Reference model: samples in flight with their due edge, plus result queue.
  typedef struct { logic [31:0] y; int due; } item_t;
  item_t       inflight[$];
  logic [31:0] mfifo[$];
  int          edge_n = 0;
  int          passed = 0;
  int          total  = 0;

  logic        obs_in_ready, obs_out_valid, obs_out_class, obs_busy;
  logic [31:0] obs_out_y;
  logic        exp_in_ready, exp_out_valid, exp_out_class, exp_busy;
  logic [31:0] exp_out_y;
  logic        did_acc, did_pop;

  function automatic logic [159:0] rand_x();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int sm_val(input logic [15:0] v);
    return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
  endfunction

  function automatic logic ref_class(input logic [31:0] y);
    return sm_val(y[31:16]) > sm_val(y[15:0]);
  endfunction

  // One clock cycle: drive inputs, sample outputs and model expectations
  // before the edge, then advance the model across the edge.
  task automatic tick(input logic vin, input logic [159:0] x, input logic ordy, input logic fl);
    item_t it;
    bus.in_valid = vin; bus.in_x = x; bus.out_ready = ordy; flush = fl;
    #1;
    obs_in_ready  = bus.in_ready;  obs_out_valid = bus.out_valid;
    obs_out_y     = bus.out_y;     obs_out_class = bus.out_class;  obs_busy = busy;
    exp_out_valid = (mfifo.size() != 0);
    exp_out_y     = exp_out_valid ? mfifo[0] : 32'h0;
    exp_out_class = exp_out_valid ? ref_class(exp_out_y) : 1'b0;
    exp_in_ready  = !fl && ((DEPTH - inflight.size() - mfifo.size()) != 0);
    exp_busy      = (inflight.size() != 0) || (mfifo.size() != 0);
    did_acc = vin && obs_in_ready;
    did_pop = obs_out_valid && ordy && !fl;
    @(posedge clk);
    edge_n++;
    if (fl) begin
      inflight.delete(); mfifo.delete();
    end else begin
      if (did_pop && mfifo.size() != 0) void'(mfifo.pop_front());
      while (inflight.size() != 0 && inflight[0].due == edge_n) begin
        it = inflight.pop_front();
        mfifo.push_back(it.y);
      end
      if (did_acc) begin
        it.y = x[31:0]; it.due = edge_n + LATENCY;
        inflight.push_back(it);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; flush = 1'b0; reset = 1'b0;
    inflight.delete(); mfifo.delete();
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.in_valid = 1'b1; bus.in_x = rand_x(); bus.out_ready = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else passed++;
    total++; if (bus.out_y !== 32'h0) $display("FAIL rst_out_y got=%h exp=0", bus.out_y); else passed++;
    total++; if (bus.out_class !== 1'b0) $display("FAIL rst_out_class got=%b exp=0", bus.out_class); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
    total++; if (dp_x !== 160'h0) $display("FAIL rst_dp_x got=%h exp=0", dp_x); else passed++;
    bus.in_valid = 1'b0; reset = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL rel_in_ready got=%b exp=1", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rel_out_valid got=%b exp=0", bus.out_valid); else passed++;
    // Asynchronous reset in the middle of activity.
    repeat (3) tick(1'b1, rand_x(), 1'b0, 1'b0);
    repeat (26) tick(1'b0, rand_x(), 1'b0, 1'b0);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL pre_async_valid got=%b exp=1", bus.out_valid); else passed++;
    reset = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL async_out_valid got=%b exp=0", bus.out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL async_busy got=%b exp=0", busy); else passed++;
    total++; if (dp_x !== 160'h0) $display("FAIL async_dp_x got=%h exp=0", dp_x); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL async_in_ready got=%b exp=0", bus.in_ready); else passed++;
    inflight.delete(); mfifo.delete();
    @(posedge clk);
    #1; reset = 1'b1;
  endtask

  task automatic test_latency();
    logic [159:0] x;
    int k;
    x = rand_x(); x[31:0] = {16'h3000, 16'h2000};
    tick(1'b1, x, 1'b0, 1'b0);
    total++; if (dp_x !== x) $display("FAIL lat_dp_x got=%h exp=%h", dp_x, x); else passed++;
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 100) begin
      tick(1'b0, rand_x(), 1'b0, 1'b0);
      k++;
    end
    total++; if (k != LATENCY) $display("FAIL lat_edges got=%0d exp=%0d", k, LATENCY); else passed++;
    total++; if (dp_x !== x) $display("FAIL lat_dp_hold got=%h exp=%h", dp_x, x); else passed++;
    total++; if (bus.out_y !== 32'h30002000) $display("FAIL lat_out_y got=%h exp=30002000", bus.out_y); else passed++;
    total++; if (bus.out_class !== 1'b1) $display("FAIL lat_out_class got=%b exp=1", bus.out_class); else passed++;
    tick(1'b0, rand_x(), 1'b1, 1'b0);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL lat_after_pop got=%b exp=0", bus.out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    int pops = 0, first = -1, last = -1;
    for (int c = 0; c < 200; c++) begin
      tick(c < 100, rand_x(), 1'b1, 1'b0);
      total++; if (obs_in_ready !== exp_in_ready) $display("FAIL b2b_in_ready c=%0d got=%b exp=%b", c, obs_in_ready, exp_in_ready); else passed++;
      total++; if (obs_out_valid !== exp_out_valid) $display("FAIL b2b_out_valid c=%0d got=%b exp=%b", c, obs_out_valid, exp_out_valid); else passed++;
      if (exp_out_valid) begin
        total++; if (obs_out_y !== exp_out_y) $display("FAIL b2b_out_y c=%0d got=%h exp=%h", c, obs_out_y, exp_out_y); else passed++;
      end
      if (did_pop) begin pops++; if (first < 0) first = c; last = c; end
      if (c >= 100 && inflight.size() == 0 && mfifo.size() == 0) break;
    end
    total++; if (pops != 100) $display("FAIL b2b_count got=%0d exp=100", pops); else passed++;
    total++; if (first != LATENCY + 1) $display("FAIL b2b_first got=%0d exp=%0d", first, LATENCY + 1); else passed++;
    total++; if (last - first != 99) $display("FAIL b2b_span got=%0d exp=99", last - first); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_busy_end got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_backpressure();
    logic [159:0] xs [40];
    int sent = 0, got = 0;
    for (int i = 0; i < 40; i++) xs[i] = rand_x();
    for (int c = 0; c < 45; c++) begin
      tick(sent < 40, xs[sent < 40 ? sent : 0], 1'b0, 1'b0);
      total++; if (obs_in_ready !== exp_in_ready) $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, obs_in_ready, exp_in_ready); else passed++;
      if (did_acc) sent++;
    end
    total++; if (sent != DEPTH) $display("FAIL bp_accepts got=%0d exp=%0d", sent, DEPTH); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL bp_busy got=%b exp=1", busy); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_low got=%b exp=0", bus.in_ready); else passed++;
    for (int c = 0; c < 150 && got < 40; c++) begin
      tick(sent < 40, xs[sent < 40 ? sent : 0], 1'b1, 1'b0);
      total++; if (obs_out_valid !== exp_out_valid) $display("FAIL bp_out_valid c=%0d got=%b exp=%b", c, obs_out_valid, exp_out_valid); else passed++;
      if (exp_out_valid) begin
        total++; if (obs_out_y !== exp_out_y) $display("FAIL bp_out_y c=%0d got=%h exp=%h", c, obs_out_y, exp_out_y); else passed++;
      end
      if (did_acc) sent++;
      if (did_pop) got++;
    end
    total++; if (got != 40) $display("FAIL bp_results got=%0d exp=40", got); else passed++;
    tick(1'b0, rand_x(), 1'b1, 1'b0);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_no_dup got=%b exp=0", bus.out_valid); else passed++;
  endtask

  task automatic test_flush();
    logic [159:0] last_x;
    int any_valid = 0;
    do_reset();
    for (int i = 0; i < 13; i++) begin last_x = rand_x(); tick(1'b1, last_x, 1'b0, 1'b0); end
    repeat (14) tick(1'b0, rand_x(), 1'b0, 1'b0);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL fl_pre_valid got=%b exp=1", bus.out_valid); else passed++;
    tick(1'b1, rand_x(), 1'b1, 1'b1);
    total++; if (obs_in_ready !== 1'b0) $display("FAIL fl_in_ready got=%b exp=0", obs_in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL fl_out_valid got=%b exp=0", bus.out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL fl_busy got=%b exp=0", busy); else passed++;
    total++; if (dp_x !== last_x) $display("FAIL fl_dp_x got=%h exp=%h", dp_x, last_x); else passed++;
    for (int c = 0; c < 30; c++) begin
      tick(1'b0, rand_x(), 1'b1, 1'b0);
      if (bus.out_valid === 1'b1) any_valid++;
    end
    total++; if (any_valid != 0) $display("FAIL fl_late_capture got=%0d exp=0", any_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL fl_in_ready_after got=%b exp=1", bus.in_ready); else passed++;
`ifdef ARR_PERF_CNT_EN
    total++; if (perf_in_cnt !== 32'd13) $display("FAIL fl_perf_in got=%0d exp=13", perf_in_cnt); else passed++;
    total++; if (perf_out_cnt !== 32'd0) $display("FAIL fl_perf_out got=%0d exp=0", perf_out_cnt); else passed++;
`endif
  endtask

  task automatic test_class();
    logic [31:0] corners [4];
    logic        cexp [4];
    logic [159:0] x;
    int w = 0;
    corners[0] = {16'h8005, 16'h0001}; cexp[0] = 1'b0;
    corners[1] = {16'h0001, 16'h8005}; cexp[1] = 1'b1;
    corners[2] = {16'h0400, 16'h0400}; cexp[2] = 1'b0;
    corners[3] = {16'h8000, 16'h0000}; cexp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin x = rand_x(); x[31:0] = corners[i]; tick(1'b1, x, 1'b0, 1'b0); end
    while (mfifo.size() < 4 && w < 60) begin tick(1'b0, rand_x(), 1'b0, 1'b0); w++; end
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.out_y !== corners[i]) $display("FAIL cls_y%0d got=%h exp=%h", i, bus.out_y, corners[i]); else passed++;
      total++; if (bus.out_class !== cexp[i]) $display("FAIL cls_c%0d got=%b exp=%b", i, bus.out_class, cexp[i]); else passed++;
      tick(1'b0, rand_x(), 1'b0, 1'b0);
      total++; if (bus.out_y !== corners[i]) $display("FAIL cls_stable%0d got=%h exp=%h", i, bus.out_y, corners[i]); else passed++;
      tick(1'b0, rand_x(), 1'b1, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [159:0] x;
    logic [15:0]  y1;
    for (int c = 0; c < 600; c++) begin
      x = rand_x(); y1 = x[31:16];
      case ($urandom_range(0, 3))
        0: x[15:0] = y1;
        1: x[15:0] = y1 ^ 16'h8000;
        2: begin x[31:16] = {y1[15], 15'h0}; x[15:0] = {~y1[15], 15'h0}; end
        default: ;
      endcase
      tick($urandom_range(0, 9) < 7, x, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 2);
      total++; if (obs_in_ready !== exp_in_ready) $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, obs_in_ready, exp_in_ready); else passed++;
      total++; if (obs_out_valid !== exp_out_valid) $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, obs_out_valid, exp_out_valid); else passed++;
      total++; if (obs_busy !== exp_busy) $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, obs_busy, exp_busy); else passed++;
      if (exp_out_valid) begin
        total++; if (obs_out_y !== exp_out_y) $display("FAIL rnd_out_y c=%0d got=%h exp=%h", c, obs_out_y, exp_out_y); else passed++;
        total++; if (obs_out_class !== exp_out_class) $display("FAIL rnd_class c=%0d got=%b exp=%b y=%h", c, obs_out_class, exp_out_class, obs_out_y); else passed++;
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_x = '0; bus.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_class();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/arrhythmia_infer_ctrl.md
Name: arrhythmia_infer_ctrl

Overview:
Sequencer and flow-control wrapper for the fixed-latency arrhythmia inference datapath (enc_1 → softplus → enc_2 mean/var → lambda → enc_3 → softplus → enc_4 → sigmoid). The datapath has no valid or stall signals. This block provides that control:
- accepts samples over a valid/ready handshake;
- tracks in-flight samples with a token shift register;
- captures datapath results into an output FIFO;
- uses credit-based issue so no result is lost under back-pressure;
- emits a 1-bit class decision per result.

Parameters:
BITSIZE, 16, element width in sign-magnitude fixed point (bit BITSIZE-1 = sign).
LATENCY, 24, clock edges from a dp_x update to the matching dp_y; must be ≥ 2.
FIFO_DEPTH, 32, result FIFO entries; power of 2; must be ≥ LATENCY+1 for full throughput.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  sample valid.
in_ready  out  1  sample accepted on an edge where in_valid && in_ready.
in_x  in  BITSIZE*10  10-element input sample.
flush  in  1  synchronous abort of all in-flight and buffered results.
dp_x  out  BITSIZE*10  registered drive to the datapath x input.
dp_y  in  BITSIZE*2  datapath y output.
out_valid  out  1  FIFO head valid.
out_ready  in  1  consumer ready; pop on out_valid && out_ready.
out_y  out  BITSIZE*2  FIFO head result.
out_class  out  1  1 when element 1 > element 0 of out_y.
busy  out  1  any token in flight or FIFO non-empty.

Behaviour:
Reset values:
- reset is asynchronous, active-low; asserting it clears all state immediately, including mid-operation.
- During reset: dp_x=0, out_valid=0, out_y=0, out_class=0, busy=0, in_ready=0, tokens=0, FIFO empty, credit=FIFO_DEPTH.

Credit and issue:
- Credit counter width is clog2(FIFO_DEPTH+1).
- in_ready = (credit != 0) && !flush && reset released.
- Accept decrements credit; pop increments credit; accept and pop on the same edge leave credit unchanged.
- Credit is never below 0 or above FIFO_DEPTH.

Issue timing:
- On the accepting edge E0: dp_x <= in_x, and a token enters tok[0] of the LATENCY-bit shift register.
- dp_x holds its value between accepts.
- Back-to-back accepts, one per cycle, are legal.

Capture:
- At edge E0+LATENCY (tok[LATENCY-1]=1 at that edge), dp_y is written into the FIFO.
- out_valid is therefore high from edge E0+LATENCY.
- The credit scheme guarantees the FIFO never overflows; push into a full FIFO is unreachable (assertion).

FIFO:
- First-word-fall-through, in order.
- out_y and out_class are stable while out_valid && !out_ready.
- Push and pop on the same edge are both performed; a push into an empty FIFO is visible the next cycle.
- Read and write pointers are log2(FIFO_DEPTH) bits plus a wrap bit.
- Full: pointers equal except the wrap bit. Empty: pointers fully equal.

out_class:
- Computed from the FIFO head as a sign-magnitude compare of y[2*BITSIZE-1:BITSIZE] vs y[BITSIZE-1:0].
- A negative value is less than a positive value.
- +0 and -0 are equal.
- Ties give 0.

flush:
- Sampled on the edge: tokens <= 0, FIFO emptied, credit <= FIFO_DEPTH.
- A pop in the same cycle is discarded; a capture due on that edge is dropped.
- in_ready=0 during the flush cycle.
- dp_x is retained.
- busy=0 from the following cycle.

busy = |tok || !fifo_empty.

Optional Feature:
Macro ARR_PERF_CNT_EN.
- Defined: adds three 32-bit saturating output ports, each cleared only by reset:
  - perf_in_cnt: counts accepts;
  - perf_out_cnt: counts pops;
  - perf_stall_cnt: counts cycles with out_valid && !out_ready.
- Not defined: these ports and their logic are absent, and the block is otherwise identical.

Test Plan:
1. Hold reset low with in_valid=1 → in_ready=0 and all outputs 0. Release → in_ready=1 on the first cycle; no spurious out_valid.
2. Use a stub datapath (LATENCY-deep delay, y = x[31:0]). Accept in_x[31:0]={16'h3000,16'h2000} at E0 → out_valid at E0+24, out_y=32'h30002000, out_class=1.
3. Send 100 back-to-back samples with out_ready=1 → in_ready never drops; 100 results in order, one per cycle after the initial latency; credit ends at 32.
4. Hold out_ready=0 and offer 40 samples → in_ready drops after exactly 32 accepts; busy=1. Raise out_ready → 32 results, then the remaining 8, with no loss or duplication.
5. Assert flush for one cycle with 10 tokens in flight and 3 results buffered → out_valid=0 and busy=0 next cycle; no later captures; in_ready=1 after flush. With ARR_PERF_CNT_EN: perf_in_cnt=13, perf_out_cnt=0.
6. Class-compare corners on the FIFO head:
   - y1=16'h8005, y0=16'h0001 → 0;
   - y1=16'h0001, y0=16'h8005 → 1;
   - y1=y0=16'h0400 → 0;
   - y1=16'h8000, y0=16'h0000 → 0.
